mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the data-port MMIO path. It decodes CPU data-port accesses to `MMIO_ADDR_UART` (from Constants.vh) and serialises written bytes onto `uart_tx` as 8N1 frames. It produces the `mmio_uart_done` strobe that the memory block turns into `data_done` for the CPU. Writes block the CPU until the stop bit has been sent; reads complete immediately.

## Interface
- CLK_FREQ, 27000000, system clock frequency in Hz
- BAUD, 115200, line rate; DIV = CLK_FREQ / BAUD (integer floor), DIV >= 2 required
- clock  in  1  system clock, all logic on posedge
- reset  in  1  reset, synchronous, active-high
- data_addr  in  16  CPU data-port address (same net the memory block sees)
- data_in  in  8  CPU write byte
- data_write  in  1  1 = write, 0 = read; qualified by data_req
- data_req  in  1  CPU access request; held high until the CPU sees data_done
- mmio_uart_done  out  1  one-cycle completion pulse to the memory block
- uart_tx  out  1  serial line, idle high
- busy  out  1  high while a frame is in flight (IDLE excluded)

## Operation
- hit = data_req && (data_addr == `MMIO_ADDR_UART).
- armed flag: reset value 1. Cleared on accept. Set again in any cycle where hit is 0. Prevents re-triggering while data_req stays high through the memory block's registered data_done.
- Accept = hit && armed && state == IDLE.
- States: IDLE, START, DATA, STOP, DONE.
  - IDLE: uart_tx = 1.
    - Accept with data_write = 1 -> latch data_in into shift register, go to START.
    - Accept with data_write = 0 -> go to DONE; no line activity.
  - START: uart_tx = 0 for DIV cycles -> DATA, bit index = 0.
  - DATA: uart_tx = shift[0], LSB first. Each bit lasts DIV cycles, then shift right. After bit 7 -> STOP.
  - STOP: uart_tx = 1 for DIV cycles -> DONE.
  - DONE: mmio_uart_done = 1 for exactly this cycle -> IDLE.
- Baud counter counts 0..DIV-1 and is cleared on every state entry. A state advances when the counter reaches DIV-1.
- The byte is latched at accept; later changes on data_in or data_addr do not affect the frame in flight.
- hit while not IDLE: ignored, no queuing. This cannot occur with a well-behaved CPU, which blocks on the pending write.
- A non-matching data_req is never acknowledged by this block.
- uart_tx and mmio_uart_done are registered outputs; no combinational path from any input.

## Timing
- Reset values: uart_tx = 1, mmio_uart_done = 0, busy = 0, state = IDLE, armed = 1, counter = 0.
- Reset applies at the next clock edge in any state. A frame in progress is aborted and uart_tx returns high. No done pulse is produced.
- Write accepted at edge T:
  - uart_tx low during cycles T+1 .. T+DIV.
  - data bit k during T+1+(k+1)·DIV .. T+(k+2)·DIV.
  - stop bit during T+1+9·DIV .. T+10·DIV.
  - mmio_uart_done high in cycle T+1+10·DIV.
- Read accepted at edge T: mmio_uart_done high in cycle T+1. uart_tx unchanged.
- The memory block raises data_done one cycle after the done pulse, and the CPU drops data_req after that. armed stays 0 until a cycle with hit = 0, so no second frame is started.
- busy is high from T+1 through the DONE cycle inclusive.
- Back-to-back writes: the next accept is possible at the earliest in the cycle after hit has been 0 for one cycle.

## Test plan
(All with CLK_FREQ=16, BAUD=4, so DIV=4.)
- Reset, then idle 20 cycles -> uart_tx = 1, mmio_uart_done = 0, busy = 0 throughout.
- Write 0xA5 to `MMIO_ADDR_UART`, req held until data_done:
  - line = 0 (4 cycles), bits 1,0,1,0,0,1,0,1 (4 cycles each), 1 (4 cycles).
  - done pulse exactly at T+41, single cycle.
  - no second frame while req remains high.
- Read from `MMIO_ADDR_UART` -> done pulse at T+1, uart_tx stays 1, busy high for one cycle only.
- Access to address `MMIO_ADDR_UART`+1 with data_req held 50 cycles -> no done, uart_tx stays 1.
- Write 0x0F and 0xF0 back-to-back, req dropped for 1 cycle between -> two complete 40-cycle frames. Second start bit no earlier than 2 cycles after the first done pulse.
- Write 0xFF, assert reset during DATA bit 3 -> uart_tx = 1 from the next cycle, no done pulse. Subsequent write 0x55 produces a correct frame.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter; a write blocks the CPU until its stop bit is sent.
`ifndef MMIO_ADDR_UART
`define MMIO_ADDR_UART 16'hFF04
`endif
module mmio_uart_tx #(
  parameter int CLK_FREQ = 27000000,
  parameter int BAUD = 115200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_addr,
  input  logic [7:0]  data_in,
  input  logic        data_write,
  input  logic        data_req,
  output logic        mmio_uart_done,
  output logic        uart_tx,
  output logic        busy
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW = $clog2(DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic armed, hit, accept, tick;
  assign hit = data_req && (data_addr == `MMIO_ADDR_UART);
  assign accept = hit && armed && (state == IDLE);
  assign tick = cnt == CW'(DIV - 1);
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n = idx;
    case (state)
      IDLE: if (accept) begin
        state_n = data_write ? START : DONE;
        shift_n = data_write ? data_in : shift;
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n = 3'd0;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: state_n = tick ? DONE : STOP;
      default: state_n = IDLE;
    endcase
    cnt_n = (tick || state == IDLE || state == DONE) ? '0 : cnt + CW'(1);
  end
  // Outputs are registered from the next-state values so the line changes on the state boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= 3'd0;
      shift <= 8'd0;
      armed <= 1'b1;
      uart_tx <= 1'b1;
      mmio_uart_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      armed <= accept ? 1'b0 : (!hit ? 1'b1 : armed);
      uart_tx <= (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
      mmio_uart_done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: table-driven directed checks of frame timing, read/miss handling and reset abort.
`ifndef MMIO_ADDR_UART
`define MMIO_ADDR_UART 16'hFF04
`endif
module tb_mmio_uart_tx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] data_addr = 16'h0;
  logic [7:0] data_in = 8'h0;
  logic data_write = 1'b0;
  logic data_req = 1'b0;
  logic mmio_uart_done, uart_tx, busy;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [15:0] addr;
    logic wr;
    logic [7:0] data;
    logic hit;
  } vec_t;
  vec_t vecs[6];
  mmio_uart_tx #(.CLK_FREQ(16), .BAUD(4)) dut (
    .clock(clock), .reset(reset), .data_addr(data_addr), .data_in(data_in),
    .data_write(data_write), .data_req(data_req), .mmio_uart_done(mmio_uart_done),
    .uart_tx(uart_tx), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, k, act, exp);
    end
  endtask
  task automatic chk3(input string nm, input int k, input logic et, input logic ed, input logic eb);
    chk({nm, " tx"}, k, uart_tx, et);
    chk({nm, " done"}, k, mmio_uart_done, ed);
    chk({nm, " busy"}, k, busy, eb);
  endtask
  // Holds req through the done pulse plus two cycles (memory block's registered data_done), then drops it.
  task automatic run_access(input logic [15:0] a, input logic w, input logic [7:0] d, input logic h, input string nm);
    int n;
    logic et, ed, eb;
    n = !h ? 50 : (w ? 43 : 3);
    @(negedge clock);
    data_addr = a;
    data_in = d;
    data_write = w;
    data_req = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (k == 2) data_in = ~d;
      if (h && w) begin
        et = (k <= 4) ? 1'b0 : (k <= 36) ? d[(k - 5) / 4] : 1'b1;
        ed = k == 41;
        eb = k <= 41;
      end else if (h) begin
        et = 1'b1;
        ed = k == 1;
        eb = k == 1;
      end else begin
        et = 1'b1;
        ed = 1'b0;
        eb = 1'b0;
      end
      chk3(nm, k, et, ed, eb);
    end
    data_req = 1'b0;
  endtask
  initial begin
    vecs[0] = '{`MMIO_ADDR_UART, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{`MMIO_ADDR_UART, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{`MMIO_ADDR_UART + 16'd1, 1'b1, 8'h33, 1'b0};
    vecs[3] = '{`MMIO_ADDR_UART, 1'b1, 8'h0F, 1'b1};
    vecs[4] = '{`MMIO_ADDR_UART, 1'b1, 8'hF0, 1'b1};
    vecs[5] = '{`MMIO_ADDR_UART + 16'd1, 1'b0, 8'h00, 1'b0};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      chk3("idle", k, 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++)
      run_access(vecs[i].addr, vecs[i].wr, vecs[i].data, vecs[i].hit, $sformatf("vec%0d", i));
    @(negedge clock);
    data_addr = `MMIO_ADDR_UART;
    data_in = 8'hFF;
    data_write = 1'b1;
    data_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clock);
      chk3("pre_reset", k, k > 4, 1'b0, 1'b1);
    end
    reset = 1'b1;
    data_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    chk3("reset_abort", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      chk3("post_reset", k, 1'b1, 1'b0, 1'b0);
    end
    run_access(`MMIO_ADDR_UART, 1'b1, 8'h55, 1'b1, "after_reset");
    @(negedge clock);
    chk3("final_idle", 0, 1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
